// File: rtl/uart_tx_frame_if.sv
// Host-side handshake and serial-line bundle for uart_tx_frame.
// The master modport is the host side and the slave modport is the transmitter.
interface uart_tx_frame_if #(
    parameter int unsigned NUM_DATA_BITS = 8
) ();
    logic [NUM_DATA_BITS-1:0] tx_data;
    logic                     tx_start;
    logic                     tx_ready;
    logic                     tx_out;
    logic                     tx_busy;
    logic                     frame_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_ready,
        input  tx_out,
        input  tx_busy,
        input  frame_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_ready,
        output tx_out,
        output tx_busy,
        output frame_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data bits, optional even parity, then one stop bit.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_frame #(
    parameter int unsigned NUM_DATA_BITS = 8,
    parameter int unsigned CLKS_PER_BIT  = 10
) (
    input logic             clk,
    input logic             rst,
    uart_tx_frame_if.slave  tx_if
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(NUM_DATA_BITS);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CntPenult = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BitLast   = BIT_W'(NUM_DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
    logic parity_q;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                   state_q;
    logic [CNT_W-1:0]         clk_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [NUM_DATA_BITS-1:0] shreg_q;
    logic                     tx_out_q;
    logic                     tx_ready_q;
    logic                     tx_busy_q;
    logic                     frame_done_q;
    logic                     accept;

    assign accept = tx_if.tx_start && tx_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            tx_out_q     <= 1'b1;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            // Accept is only possible in idle or on the final stop cycle.
            if (accept) begin
                state_q    <= StStart;
                clk_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                shreg_q    <= tx_if.tx_data;
                tx_out_q   <= 1'b0;
                tx_ready_q <= 1'b0;
                tx_busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_q   <= ^tx_if.tx_data;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        clk_cnt_q <= '0;
                    end
                    StStart: begin
                        if (clk_cnt_q == CntLast) begin
                            clk_cnt_q <= '0;
                            state_q   <= StData;
                            tx_out_q  <= shreg_q[0];
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (clk_cnt_q == CntLast) begin
                            clk_cnt_q <= '0;
                            if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                                state_q  <= StParity;
                                tx_out_q <= parity_q;
`else
                                state_q  <= StStop;
                                tx_out_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                shreg_q   <= shreg_q >> 1;
                                tx_out_q  <= shreg_q[1];
                            end
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    StParity: begin
                        if (clk_cnt_q == CntLast) begin
                            clk_cnt_q <= '0;
                            state_q   <= StStop;
                            tx_out_q  <= 1'b1;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end
                    end
`endif
                    StStop: begin
                        if (clk_cnt_q == CntLast) begin
                            clk_cnt_q <= '0;
                            state_q   <= StIdle;
                            tx_busy_q <= 1'b0;
                            tx_out_q  <= 1'b1;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                            // Ready and done are registered, so raise them one cycle early.
                            if (clk_cnt_q == CntPenult) begin
                                tx_ready_q   <= 1'b1;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign tx_if.tx_out     = tx_out_q;
    assign tx_if.tx_ready   = tx_ready_q;
    assign tx_if.tx_busy    = tx_busy_q;
    assign tx_if.frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at the default parameters (8 data bits, 10 clocks per bit).
// Expected frame length and parity placement follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;
    localparam logic [3:0] IdleSt = 4'b1010; // {tx_out, tx_busy, tx_ready, frame_done}

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    uart_tx_frame_if #(.NUM_DATA_BITS(8)) tx_if ();

    uart_tx_frame #(
        .NUM_DATA_BITS(8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tx_if(tx_if)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] status();
        return {tx_if.tx_out, tx_if.tx_busy, tx_if.tx_ready, tx_if.frame_done};
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {out,busy,ready,done}=%b, want %b", name, act, exp);
        end
    endtask

    function automatic logic exp_level(input logic [7:0] d, input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (NBITS == 11 && b == 9) return p;
        return 1'b1;
    endfunction

    // Checks every cycle of a frame whose accept edge has just passed.
    // inj_at: cycle at which a one-cycle stray tx_start (8'h3C) is raised.
    // rst_at: cycle at which rst is raised for one edge; the frame is then abandoned.
    task automatic check_frame(input logic [7:0] d, input logic p, input int inj_at,
                               input int rst_at);
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            cmp($sformatf("frame_%02h_c%0d", d, k), status(),
                {exp_level(d, p, (k - 1) / CPB), 1'b1, k == FLEN, k == FLEN});
            if (k == inj_at) begin
                tx_if.tx_start = 1'b1;
                tx_if.tx_data  = 8'h3C;
            end
            if (k == inj_at + 1) tx_if.tx_start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        cmp("pre_accept", status(), IdleSt);
        tx_if.tx_data  = d;
        tx_if.tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_start = 1'b0;
        tx_if.tx_data  = ~d;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmp($sformatf("%s_%0d", name, i), status(), IdleSt);
        end
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{data: 8'hA5, par: 1'b0};
        tbl[1] = '{data: 8'h07, par: 1'b1};
        tbl[2] = '{data: 8'hC3, par: 1'b0};
        tbl[3] = '{data: 8'h01, par: 1'b1};

        tx_if.tx_data  = 8'h00;
        tx_if.tx_start = 1'b0;

        // Reset, then a long idle stretch.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles("idle", 50);

        // Single frames from the table.
        foreach (tbl[i]) begin
            send(tbl[i].data);
            check_frame(tbl[i].data, tbl[i].par, -10, -1);
            idle_cycles("post", 3);
        end

        // Back-to-back: tx_start held high across the first frame's final stop cycle.
        @(negedge clk);
        tx_if.tx_data  = 8'h00;
        tx_if.tx_start = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_data = 8'hFF;
        check_frame(8'h00, 1'b0, -10, -1);
        @(posedge clk);
        #1;
        tx_if.tx_start = 1'b0;
        tx_if.tx_data  = 8'h00;
        check_frame(8'hFF, 1'b0, -10, -1);
        idle_cycles("b2b_post", 3);

        // Stray request mid-frame is dropped.
        send(8'h5A);
        check_frame(8'h5A, 1'b0, 35, -1);
        idle_cycles("no_3c", 30);

        // Reset mid-frame, then a clean frame.
        send(8'h81);
        check_frame(8'h81, 1'b0, -10, 47);
        @(negedge clk);
        cmp("after_rst", status(), IdleSt);
        idle_cycles("rst_idle", 5);
        send(8'h81);
        check_frame(8'h81, 1'b0, -10, -1);
        idle_cycles("final", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter: the transmit-side counterpart of the team's UART receiver.
- Accepts a parallel byte over a valid/ready handshake.
- Serializes it LSB-first through an internal parallel-to-serial shift register as start bit, data bits, optional parity and stop bit.
- Each bit is held for a fixed number of clocks.
- Sits between the host-side register interface and the serial line pin.

Parameters:
NUM_DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 10, clock cycles per serial bit; legal minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high; the block uses one clock.
tx_data  input  NUM_DATA_BITS  byte to send; sampled only on the accept cycle.
tx_start  input  1  request to send tx_data.
tx_ready  output  1  block can accept a request this cycle.
tx_out  output  1  serial line, registered; idle level 1.
tx_busy  output  1  frame in progress (any state other than IDLE).
frame_done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect on that edge, including mid-frame:
  - tx_out=1, tx_ready=1, tx_busy=0, frame_done=0.
  - FSM=IDLE; bit counter and clock counter cleared.
  - Any frame in progress is abandoned and never resumed.
- Accept condition: tx_start=1 && tx_ready=1 at a rising edge.
  - tx_data is latched into the shift register on that edge.
  - tx_start while tx_ready=0 is ignored and dropped. There is no queueing.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP (or PARITY) after NUM_DATA_BITS bits.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles, or STOP -> START if an accept occurs on the final STOP cycle.
- Clock counter: counts 0..CLKS_PER_BIT-1 in each state other than IDLE, then wraps to 0 on every bit boundary. Width is $clog2(CLKS_PER_BIT).
- Bit counter: counts DATA bits 0..NUM_DATA_BITS-1.
  - The shift register shifts right by one at each DATA bit boundary.
  - tx_out takes shift register bit 0.
- tx_out levels by state: IDLE 1; START 0; DATA the current LSB; STOP 1.
- Latency: tx_out goes 0 on the first cycle after the accept edge (registered output). Every bit is exactly CLKS_PER_BIT cycles wide.
- Frame length: (2 + NUM_DATA_BITS) * CLKS_PER_BIT cycles without parity; 8-bit default with CLKS_PER_BIT=10 gives 100 cycles.
- tx_ready:
  - 1 in IDLE.
  - 1 on the final cycle of STOP.
  - 0 otherwise.
- Back-to-back: an accept on the final STOP cycle goes straight to START. The result is a gapless stream with no extra idle cycle, and frame_done still pulses on that cycle.
- tx_busy: 0 in IDLE, 1 otherwise. It stays 1 through a back-to-back transition.
- tx_data changes after the accept cycle have no effect on the frame in flight.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state of CLKS_PER_BIT cycles is inserted between DATA and STOP.
  - tx_out = even parity, i.e. XOR of the latched data bits.
  - Frame length becomes (3 + NUM_DATA_BITS) * CLKS_PER_BIT cycles.
- Undefined: no PARITY state, logic or counter width change. DATA goes directly to STOP.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, release, tx_start=0 for 50 cycles -> tx_out=1, tx_ready=1, tx_busy=0, frame_done=0 throughout.
2. Single frame (defaults, no parity): tx_data=8'hA5 with one-cycle tx_start.
   - tx_out holds 0,1,0,1,0,0,1,0,1,1, each for 10 cycles.
   - frame_done pulses on cycle 100 after accept; tx_ready returns to 1 on the same cycle.
3. Back-to-back: send 8'h00, then hold tx_start=1 with 8'hFF.
   - Second accept happens on the final STOP cycle; the next cycle's tx_out=0 (start bit), with no idle bit between frames.
   - tx_busy stays 1 across the boundary.
4. Ignored request: pulse tx_start with 8'h3C at cycle 35 of an 8'h5A frame -> the 8'h5A frame is unchanged, and no 8'h3C frame follows.
5. Reset mid-frame: assert rst at cycle 47 of a frame.
   - Next cycle: tx_out=1, tx_ready=1, tx_busy=0.
   - A fresh 8'h81 frame then sends correctly.
6. Parity build (UART_TX_PARITY_EN): 8'hA5 gives a parity bit of 0 and 8'h07 gives a parity bit of 1.
   - Each parity bit is 10 cycles long, placed before the stop bit.
   - frame_done pulses at cycle 110.
